fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues 16-bit instruction-memory reads, buffers one
// word while decode is stalled, and flushes cleanly on a taken-branch redirect.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic [15:0] imem_rdata,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        if_valid,
  output logic [15:0] if_ir,
  output logic [15:0] if_pc,
  output logic [3:0]  opcode,
  output logic        bit11,
  output logic        bit5,
  output logic        bit4,
  output logic [1:0]  state_dbg
);

  // Handshakes: a memory request is imem_read=1 with imem_address, held stable
  // until the single cycle carrying imem_resp=1, which completes it. An
  // instruction passes to decode on any rising edge with if_valid=1, stall=0.
  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    WAIT_SLOT = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] hold_ir_q, hold_ir_d;
  logic [15:0] hold_pc_q, hold_pc_d;
  logic [15:0] if_ir_q, if_ir_d;
  logic [15:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        read_q, read_d;
  logic        consumable;
  logic [15:0] next_addr;

  assign next_addr  = req_addr_q + 16'd2;
  assign consumable = !stall || !if_valid_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    hold_ir_d  = hold_ir_q;
    hold_pc_d  = hold_pc_q;
    if_ir_d    = if_ir_q;
    if_pc_d    = if_pc_q;
    // A consumed instruction is never replayed.
    if_valid_d = if_valid_q && stall;
    read_d     = read_q;

    if (redirect) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
      if_ir_d    = 16'h0000;
      hold_ir_d  = 16'h0000;
      hold_pc_d  = 16'h0000;
      // read_q is only ever set in FETCH or FLUSH, so this is an outstanding read.
      if (read_q && !imem_resp) begin
        state_d = FLUSH;
      end else begin
        state_d    = FETCH;
        read_d     = 1'b1;
        req_addr_d = redirect_pc;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (!read_q) begin
            read_d     = 1'b1;
            req_addr_d = pc_q;
          end else if (imem_resp) begin
            pc_d = next_addr;
            if (consumable) begin
              if_ir_d    = imem_rdata;
              if_pc_d    = next_addr;
              if_valid_d = 1'b1;
              req_addr_d = next_addr;
            end else begin
              hold_ir_d = imem_rdata;
              hold_pc_d = next_addr;
              read_d    = 1'b0;
              state_d   = WAIT_SLOT;
            end
          end
        end
        WAIT_SLOT: begin
          if (!stall) begin
            if_ir_d    = hold_ir_q;
            if_pc_d    = hold_pc_q;
            if_valid_d = 1'b1;
            read_d     = 1'b1;
            req_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        FLUSH: begin
          if (imem_resp) begin
            read_d     = 1'b1;
            req_addr_d = pc_q;
            state_d    = FETCH;
          end
        end
        default: begin
          state_d = FETCH;
          read_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_ir_q  <= 16'h0000;
      hold_pc_q  <= 16'h0000;
      if_ir_q    <= 16'h0000;
      if_pc_q    <= 16'h0000;
      if_valid_q <= 1'b0;
      read_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      hold_ir_q  <= hold_ir_d;
      hold_pc_q  <= hold_pc_d;
      if_ir_q    <= if_ir_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      read_q     <= read_d;
    end
  end

  assign imem_read    = read_q;
  assign imem_address = req_addr_q;
  assign if_valid     = if_valid_q;
  assign if_ir        = if_ir_q;
  assign if_pc        = if_pc_q;
  assign opcode       = if_ir_q[15:12];
  assign bit11        = if_ir_q[11];
  assign bit5         = if_ir_q[5];
  assign bit4         = if_ir_q[4];
  assign state_dbg    = state_q;

endmodule
